// File: rtl/write_checker.sv
// Snoops the data-memory write bus and checks it against NCHK programmable
// expected writes (ordered/unordered, address don't-care, strict, timeout).
module write_checker #(
  parameter int NCHK = 4,
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int TOW  = 20,
  parameter int IW   = 2
) (
  input  logic            ph1,
  input  logic            reset,
  input  logic            cfg_we,
  input  logic [IW-1:0]   cfg_idx,
  input  logic            cfg_valid,
  input  logic            cfg_addr_en,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [DW-1:0]   cfg_data,
  input  logic            ordered,
  input  logic            strict,
  input  logic [TOW-1:0]  timeout_cycles,
  input  logic            start,
  input  logic            memwrite,
  input  logic [AW-1:0]   dataadr,
  input  logic [DW-1:0]   writedata,
  output logic            busy,
  output logic            pass,
  output logic            fail,
  output logic            timeout,
  output logic [NCHK-1:0] match_vec,
  output logic [7:0]      mismatch_cnt,
  output logic [TOW-1:0]  cycles
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t          state, state_d;
  logic [NCHK-1:0] slot_valid;
  logic [NCHK-1:0] slot_aen;
  logic [AW-1:0]   slot_addr [NCHK];
  logic [DW-1:0]   slot_data [NCHK];
  logic [IW-1:0]   ptr, ptr_d, ptr_first, ptr_adv;

  logic [NCHK-1:0] cand, ptr_sel, hit_vec, new_match, match_d;
  logic [7:0]      cnt_d;
  logic [TOW-1:0]  cyc_d;
  logic            to_d, any_hit, all_done, tmo_hit, miss;

  // Slot config is frozen while a run is in progress; indices with no slot
  // simply find no matching i and are dropped.
  always_ff @(posedge ph1) begin
    if (!reset) begin
      slot_valid <= '0;
      slot_aen   <= '0;
      for (int unsigned i = 0; i < NCHK; i++) begin
        slot_addr[i] <= '0;
        slot_data[i] <= '0;
      end
    end else if (cfg_we && state != S_RUN) begin
      for (int unsigned i = 0; i < NCHK; i++) begin
        if (cfg_idx == IW'(i)) begin
          slot_valid[i] <= cfg_valid;
          slot_aen[i]   <= cfg_addr_en;
          slot_addr[i]  <= cfg_addr;
          slot_data[i]  <= cfg_data;
        end
      end
    end
  end

  always_comb begin
    cand      = '0;
    ptr_sel   = '0;
    ptr_first = '0;
    ptr_adv   = ptr;
    for (int unsigned i = 0; i < NCHK; i++) begin
      cand[i]    = slot_valid[i] && !match_vec[i] && (writedata == slot_data[i]) &&
                   (!slot_aen[i] || dataadr == slot_addr[i]);
      ptr_sel[i] = (ptr == IW'(i));
    end
    for (int unsigned i = NCHK; i > 0; i--) begin
      if (slot_valid[i-1]) ptr_first = IW'(i - 1);
      if (slot_valid[i-1] && IW'(i - 1) > ptr) ptr_adv = IW'(i - 1);
    end
    hit_vec   = memwrite ? (ordered ? (cand & ptr_sel) : cand) : '0;
    any_hit   = |hit_vec;
    miss      = memwrite && !any_hit;
    new_match = match_vec | hit_vec;
    all_done  = ((slot_valid & ~new_match) == '0);
    tmo_hit   = (timeout_cycles != '0) && (cycles == timeout_cycles - 1'b1);
  end

  always_comb begin
    state_d = state;
    match_d = match_vec;
    cnt_d   = mismatch_cnt;
    cyc_d   = cycles;
    to_d    = timeout;
    ptr_d   = ptr;
    case (state)
      S_RUN: begin
        match_d = new_match;
        if (miss && mismatch_cnt != 8'hff) cnt_d = mismatch_cnt + 8'd1;
        if (ordered && any_hit) ptr_d = ptr_adv;
        // Completion outranks both failure causes; strict outranks timeout.
        if (all_done) begin
          state_d = S_PASS;
        end else if (miss && strict) begin
          state_d = S_FAIL;
          to_d    = 1'b0;
        end else if (tmo_hit) begin
          state_d = S_FAIL;
          to_d    = 1'b1;
        end else if (cycles != '1) begin
          cyc_d = cycles + 1'b1;
        end
      end
      default: begin
        if (start) begin
          state_d = S_RUN;
          match_d = '0;
          cnt_d   = '0;
          cyc_d   = '0;
          to_d    = 1'b0;
          ptr_d   = ptr_first;
        end
      end
    endcase
  end

  always_ff @(posedge ph1) begin
    if (!reset) begin
      state        <= S_IDLE;
      match_vec    <= '0;
      mismatch_cnt <= '0;
      cycles       <= '0;
      timeout      <= 1'b0;
      ptr          <= '0;
    end else begin
      state        <= state_d;
      match_vec    <= match_d;
      mismatch_cnt <= cnt_d;
      cycles       <= cyc_d;
      timeout      <= to_d;
      ptr          <= ptr_d;
    end
  end

  assign busy = (state == S_RUN);
  assign pass = (state == S_PASS);
  assign fail = (state == S_FAIL);

endmodule

// File: doc/write_checker.md
Name: write_checker

Overview:
- Synthesizable successor to the bench-level "expect one store" check used in the MIPS regression.
- Snoops the core's data-memory write bus (memwrite/dataadr/writedata) and compares it against NCHK programmable expected writes.
- Supports ordered or unordered matching, optional address don't-care, a strict mode and a cycle timeout.
- Reports pass/fail/timeout, so one bench or FPGA harness can self-check many programs without per-test case statements.

Parameters:
NCHK, 4, number of expected-write slots (1..16)
AW, 32, address width
DW, 32, data width
TOW, 20, width of cycle/timeout counter
IW, 2, slot index width (must be >= clog2(NCHK))

Ports:
ph1  in  1  single clock; all state changes on posedge ph1
reset  in  1  synchronous reset, active-low (reset==0 resets on posedge ph1)
cfg_we  in  1  write slot cfg_idx (accepted only when not in RUN)
cfg_idx  in  IW  slot index
cfg_valid  in  1  slot participates in the check
cfg_addr_en  in  1  1=compare address, 0=address don't-care
cfg_addr  in  AW  expected address
cfg_data  in  DW  expected data
ordered  in  1  1=slots must match in index order
strict  in  1  1=any non-matching write fails the run
timeout_cycles  in  TOW  run limit in cycles; 0=no limit
start  in  1  one-cycle arm pulse
memwrite  in  1  snooped store strobe
dataadr  in  AW  snooped address
writedata  in  DW  snooped data
busy  out  1  state==RUN
pass  out  1  state==PASS
fail  out  1  state==FAIL
timeout  out  1  fail was caused by timeout
match_vec  out  NCHK  per-slot matched flags
mismatch_cnt  out  8  non-matching writes this run, saturating at 255
cycles  out  TOW  cycles spent in RUN

Behaviour:
- States: IDLE, RUN, PASS, FAIL.
- Reset: all outputs 0, state IDLE, all slot valid bits 0.
- Slot config:
  - cfg_we in IDLE/PASS/FAIL writes the slot on the next edge.
  - cfg_we in RUN is ignored.
  - cfg_idx >= NCHK is ignored.
- Start:
  - start in IDLE/PASS/FAIL -> RUN on the next edge.
  - On that edge: clear match_vec, mismatch_cnt, cycles, timeout; set ordered pointer to the lowest valid slot.
  - start in RUN is ignored.
- Zero valid slots at start: enter RUN, then PASS on the following edge.
- RUN, each cycle:
  - cycles increments, saturating at all-ones.
  - On memwrite, a slot hits if it is valid, not yet matched, data equal, and (!addr_en or address equal).
- Unordered mode:
  - Every hitting slot sets its match bit.
  - Duplicate expected pairs are consumed together by one write.
- Ordered mode:
  - Only the pointer slot may hit.
  - On a hit, the pointer advances to the next higher valid slot.
  - A write equal to a later slot but not the pointer slot is a mismatch.
- Mismatch: memwrite with no hit increments mismatch_cnt. If strict, RUN -> FAIL, timeout=0.
- Latency: a write sampled at edge t updates match_vec at edge t.
  - If that write completes all valid slots, the state is PASS after the same edge, so pass is visible one cycle after the strobe.
- Timeout: if timeout_cycles!=0 and cycles==timeout_cycles-1 with slots still unmatched, RUN -> FAIL with timeout=1.
- Priority in the same cycle:
  - A completing match beats timeout (PASS).
  - A strict mismatch and timeout together -> FAIL, timeout=0.
- PASS/FAIL hold; match_vec, mismatch_cnt and cycles freeze. memwrite is ignored.
- reset==0 mid-RUN aborts to IDLE and clears config.

Test Plan:
- Unordered, slot0 = {0x14, 21, addr_en=1}, start, writes (0x10,5), (0x14,21) -> match_vec=0001, pass one cycle after the second write, mismatch_cnt=1.
- Ordered, slot0 = (0x4,2), slot1 = (0x4,6), writes (0x4,6) then (0x4,2) -> match_vec=0001, mismatch_cnt=1; then (0x4,6) -> pass.
- Strict, slot0 = (0x204,7), write (0x200,7) -> fail=1, timeout=0, match_vec=0.
- Address don't-care, slot0 data=479001600, addr_en=0, write (0x7ffc,479001600) -> pass.
- timeout_cycles=100, no matching write -> fail=1 and timeout=1 exactly 100 cycles after start, cycles=99.
- reset=0 during RUN -> all outputs 0 next edge; start without reprogramming -> pass (no valid slots) two cycles after start.
